// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: multi-cycle signed multiply/divide built around one shared add/subtract datapath.
// Shift-add multiply and restoring divide on operand magnitudes, with sign fix-up in the DONE cycle.
`default_nettype none

module multdiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_operandA,
  input  logic [DATA_WIDTH-1:0] data_operandB,
  input  logic                  ctrl_MULT,
  input  logic                  ctrl_DIV,
  output logic [DATA_WIDTH-1:0] data_result,
  output logic                  data_exception,
  output logic                  data_resultRDY,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]         LAST      = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]         COUNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] ONE       = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [CW-1:0]         count;
  logic                  op_div;
  logic                  sign;
  logic                  b_zero;
  logic [DATA_WIDTH-1:0] operand;   // |A| for multiply, |B| for divide
  logic [DATA_WIDTH-1:0] hi;        // product high word / partial remainder
  logic [DATA_WIDTH-1:0] lo;        // multiplier bits / dividend bits -> quotient

  logic                  start;
  logic [DATA_WIDTH-1:0] mag_a;
  logic [DATA_WIDTH-1:0] mag_b;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] add_a;
  logic [DATA_WIDTH-1:0] add_b;
  logic                  add_op;
  logic [DATA_WIDTH:0]   add_out;
  logic [DATA_WIDTH-1:0] fin_result;
  logic                  fin_exc;

  // A start coinciding with the RDY cycle is dropped so the result pulse is never overlapped.
  assign start = (state == IDLE) && !data_resultRDY && (ctrl_MULT || ctrl_DIV);
  assign busy  = (state != IDLE) || data_resultRDY;

  // Two's complement negation of the most negative value yields 2^(W-1), which is correct unsigned.
  assign mag_a   = data_operandA[DATA_WIDTH-1] ? (~data_operandA + ONE) : data_operandA;
  assign mag_b   = data_operandB[DATA_WIDTH-1] ? (~data_operandB + ONE) : data_operandB;
  assign shifted = {hi[DATA_WIDTH-2:0], lo[DATA_WIDTH-1]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (count == LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Shared adder: bit add_op selects subtract (a + ~b + 1); carry out means no borrow.
  always_comb begin
    add_a  = hi;
    add_b  = operand;
    add_op = 1'b0;
    if (state == DONE) begin
      add_a  = '0;
      add_b  = lo;
      add_op = 1'b1;
    end else if (op_div) begin
      add_a  = shifted;
      add_op = 1'b1;
    end
  end

  assign add_out = {1'b0, add_a} + {1'b0, (add_op ? ~add_b : add_b)}
                 + {{DATA_WIDTH{1'b0}}, add_op};

  always_comb begin
    fin_result = lo;
    fin_exc    = 1'b0;
    if (op_div) begin
      if (b_zero) begin
        fin_exc    = 1'b1;
        fin_result = '0;
      end else if (!sign && lo[DATA_WIDTH-1]) begin
        fin_exc    = 1'b1;
      end else if (sign) begin
        fin_result = add_out[DATA_WIDTH-1:0];
      end
    end else begin
      // A magnitude of exactly 2^(W-1) is representable only when the result is negative.
      fin_exc = (|hi) || (lo[DATA_WIDTH-1] && !(sign && (lo[DATA_WIDTH-2:0] == '0)));
      if (sign) fin_result = add_out[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count          <= '0;
      op_div         <= 1'b0;
      sign           <= 1'b0;
      b_zero         <= 1'b0;
      operand        <= '0;
      hi             <= '0;
      lo             <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count  <= '0;
            op_div <= !ctrl_MULT;
            sign   <= data_operandA[DATA_WIDTH-1] ^ data_operandB[DATA_WIDTH-1];
            b_zero <= (data_operandB == '0);
            hi     <= '0;
            if (ctrl_MULT) begin
              operand <= mag_a;
              lo      <= mag_b;
            end else begin
              operand <= mag_b;
              lo      <= mag_a;
            end
          end
        end
        RUN: begin
          count <= count + COUNT_ONE;
          if (op_div) begin
            hi <= add_out[DATA_WIDTH] ? add_out[DATA_WIDTH-1:0] : shifted;
            lo <= {lo[DATA_WIDTH-2:0], add_out[DATA_WIDTH]};
          end else if (lo[0]) begin
            {hi, lo} <= {add_out, lo[DATA_WIDTH-1:1]};
          end else begin
            {hi, lo} <= {1'b0, hi, lo[DATA_WIDTH-1:1]};
          end
        end
        DONE: begin
          data_resultRDY <= 1'b1;
          data_result    <= fin_result;
          data_exception <= fin_exc;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_sequencer.sv
// Scoreboard bench for multdiv_sequencer: directed operations with hand-computed results and RDY timing.
`timescale 1ns/1ps
`default_nettype none

module tb_multdiv_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] opa   = '0;
  logic [31:0] opb   = '0;
  logic        mult  = 1'b0;
  logic        div   = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .ctrl_MULT      (mult),
    .ctrl_DIV       (div),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          rdy_edge;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        check_idle = 1'b0;
  logic [31:0] idle_res = '0;
  logic        idle_exc = 1'b0;
  logic        tb_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: pops one expectation per RDY pulse and checks idle outputs when asked.
  always @(negedge clock) begin
    if (tb_done) begin
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL pending: %0d results never arrived, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end else begin
      if (data_resultRDY) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rdy: got RDY at edge %0d, required none", edge_cnt);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, " result"}, data_result, e.res);
          chk({e.name, " exception"}, {31'b0, data_exception}, {31'b0, e.exc});
          chk({e.name, " rdy_edge"}, edge_cnt, e.rdy_edge);
          chk({e.name, " busy_at_rdy"}, {31'b0, busy}, 32'd1);
        end
      end
      if (check_idle) begin
        chk("idle busy", {31'b0, busy}, 32'd0);
        chk("idle result", data_result, idle_res);
        chk("idle exception", {31'b0, data_exception}, {31'b0, idle_exc});
      end
    end
  end

  task automatic push_exp(input logic [31:0] r, input logic x, input int ed, input string nm);
    exp_t e;
    e.res = r;
    e.exc = x;
    e.rdy_edge = ed;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clock);
    end
  endtask

  task automatic idle_hold(input logic [31:0] r, input logic x);
    @(negedge clock);
    idle_res   = r;
    idle_exc   = x;
    check_idle = 1'b1;
    repeat (3) @(negedge clock);
    check_idle = 1'b0;
  endtask

  // Called at a negedge; the start is sampled on the next rising edge.
  task automatic run_op(input logic [31:0] oa, input logic [31:0] ob, input logic m, input logic d,
                        input logic [31:0] er, input logic ee, input string nm, input int repulse);
    opa  = oa;
    opb  = ob;
    mult = m;
    div  = d;
    push_exp(er, ee, edge_cnt + 1 + 33, nm);
    @(negedge clock);
    mult = 1'b0;
    div  = 1'b0;
    opa  = $urandom;
    opb  = $urandom;
    for (int i = 1; i < 60; i++) begin
      if (sb.size() == 0) break;
      if (i == repulse) begin
        opa = 32'd7;
        opb = 32'd2;
        div = 1'b1;
      end else begin
        div = 1'b0;
      end
      @(negedge clock);
    end
    div = 1'b0;
    idle_hold(er, ee);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clock);
    idle_res   = '0;
    idle_exc   = 1'b0;
    check_idle = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (100) @(negedge clock);
    check_idle = 1'b0;

    run_op(32'd3,        32'hFFFF_FFF9, 1'b1, 1'b0, 32'hFFFF_FFEB, 1'b0, "mul_3_m7",        0);
    run_op(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, "mul_ovf",        0);
    run_op(32'h8000_0000, 32'd1,        1'b1, 1'b0, 32'h8000_0000, 1'b0, "mul_min_1",       0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 1'b1, "mul_min_m1",     0);
    run_op(32'd0,        32'hFFFF_FFFB, 1'b1, 1'b0, 32'h0000_0000, 1'b0, "mul_0_m5",        0);
    run_op(32'd12,       32'hFFFF_FFFD, 1'b1, 1'b1, 32'hFFFF_FFDC, 1'b0, "both_mult_wins",  0);
    run_op(32'hFFFF_FF9C, 32'd7,        1'b0, 1'b1, 32'hFFFF_FFF2, 1'b0, "div_m100_7",      0);
    run_op(32'd5,        32'd0,         1'b0, 1'b1, 32'h0000_0000, 1'b1, "div_by_zero",     0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b1, "div_min_m1",     10);
    run_op(32'd7,        32'hFFFF_FFFE, 1'b0, 1'b1, 32'hFFFF_FFFD, 1'b0, "div_7_m2",        0);
    run_op(32'h8000_0000, 32'd1,        1'b0, 1'b1, 32'h8000_0000, 1'b0, "div_min_1",       0);

    // Start held through the RDY cycle: ignored on that edge, accepted on the following one.
    opa  = 32'hFFFF_FFFB;
    opb  = 32'hFFFF_FFFC;
    mult = 1'b1;
    push_exp(32'd20, 1'b0, edge_cnt + 1 + 33, "mul_m5_m4");
    @(negedge clock);
    mult = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (data_resultRDY) break;
      @(negedge clock);
    end
    opa  = 32'd6;
    opb  = 32'd5;
    mult = 1'b1;
    push_exp(32'd30, 1'b0, edge_cnt + 2 + 33, "mul_held_start");
    repeat (2) @(negedge clock);
    mult = 1'b0;
    drain(60);
    idle_hold(32'd30, 1'b0);

    // Reset during a running multiply: no RDY may follow for the aborted operation.
    opa  = 32'd9;
    opb  = 32'd9;
    mult = 1'b1;
    @(negedge clock);
    mult = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    idle_res   = '0;
    idle_exc   = 1'b0;
    check_idle = 1'b1;
    @(negedge clock);
    reset = 1'b1;
    repeat (40) @(negedge clock);
    check_idle = 1'b0;

    run_op(32'd6, 32'd7, 1'b1, 1'b0, 32'd42, 1'b0, "mul_6_7_after_reset", 0);

    drain(60);
    tb_done = 1'b1;
  end

endmodule

`default_nettype wire
